// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: default geometry, rotate width, magic constants and
// the decryptor state encoding. Used by rc5_rotr and rc5_decrypt.
package rc5_pkg;

  localparam int DEF_W = 32;
  localparam int DEF_R = 12;
  localparam int DEF_T = 2 * DEF_R + 2;
  localparam int ROTW  = $clog2(DEF_W);

  // Key-schedule constants, kept here so the key-mixer uses the same values
  localparam logic [31:0] P32 = 32'hB7E1_5163;
  localparam logic [31:0] Q32 = 32'h9E37_79B9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_S  = 3'd2,
    READ_S  = 3'd3,
    SUB     = 3'd4,
    ROT     = 3'd5,
    FIN_SUB = 3'd6,
    DONE    = 3'd7
  } rc5DecState_t;

endpackage

// File: rtl/rc5_rotr.sv
// Combinational W-bit right rotator; a rotate amount of zero is the identity.
module rc5_rotr
  import rc5_pkg::*;
#(
  parameter  int W  = DEF_W,
  localparam int RW = $clog2(W)
) (
  input  logic [W-1:0]  iData,
  input  logic [RW-1:0] iRot,
  output logic [W-1:0]  oData
);

  // Shifting the doubled word right lets the wrapped bits fall into the low half
  assign oData = W'({iData, iData} >> iRot);

endmodule

// File: rtl/rc5_decrypt.sv
// Iterative RC5-W/R decryption core: one half-round per four cycles using a
// single subtractor and one shared right-rotator; reads S[2R+1] down to S[0]
// from the synchronous key RAM. Optional abort input under RC5_DEC_ABORT_EN.
module rc5_decrypt
  import rc5_pkg::*;
#(
  parameter  int W   = DEF_W,
  parameter  int R   = DEF_R,
  localparam int T   = 2 * R + 2,
  localparam int AW  = $clog2(T),
  localparam int RTW = $clog2(W),
  localparam int CW  = $clog2(R + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iStart,
  input  logic [W-1:0]  iA,
  input  logic [W-1:0]  iB,
`ifdef RC5_DEC_ABORT_EN
  input  logic          iAbort,
`endif
  output logic [AW-1:0] oS_address,
  input  logic [W-1:0]  iS_sub_i,
  output logic [W-1:0]  oA,
  output logic [W-1:0]  oB,
  output logic          oDone
);

  rc5DecState_t   state_r;
  rc5DecState_t   stateNext_s;
  logic [W-1:0]   aWork_r;
  logic [W-1:0]   bWork_r;
  logic [AW-1:0]  addr_r;
  logic [CW-1:0]  round_r;
  logic           tgtA_r;
  logic           done_r;

  logic           abort_s;
  logic           finalMode_s;
  logic           lastAddr_s;
  logic           doLoad_s;
  logic           doSub_s;
  logic           doRot_s;
  logic           doFin_s;
  logic [W-1:0]   rotIn_s;
  logic [RTW-1:0] rotAmt_s;
  logic [W-1:0]   rotOut_s;
  logic [W-1:0]   subRes_s;

`ifdef RC5_DEC_ABORT_EN
  assign abort_s = iAbort && (state_r != IDLE);
`else
  assign abort_s = 1'b0;
`endif

  assign finalMode_s = (round_r == CW'(0));
  assign lastAddr_s  = (addr_r == AW'(0));

  // State register; reset and abort both return to IDLE
  always_ff @(posedge clk) begin
    if (rst || abort_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (iStart) stateNext_s = LOAD;
        else        stateNext_s = IDLE;
      end
      LOAD:   stateNext_s = WAIT_S;
      WAIT_S: stateNext_s = READ_S;
      READ_S: begin
        if (finalMode_s) stateNext_s = FIN_SUB;
        else             stateNext_s = SUB;
      end
      SUB:    stateNext_s = ROT;
      ROT:    stateNext_s = WAIT_S;
      FIN_SUB: begin
        if (lastAddr_s) stateNext_s = DONE;
        else            stateNext_s = WAIT_S;
      end
      DONE: begin
        if (iStart) stateNext_s = LOAD;
        else        stateNext_s = DONE;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Per-state datapath controls and the shared subtract/rotate operand muxes
  always_comb begin
    doLoad_s = 1'b0;
    doSub_s  = 1'b0;
    doRot_s  = 1'b0;
    doFin_s  = 1'b0;
    case (state_r)
      LOAD:    doLoad_s = 1'b1;
      SUB:     doSub_s  = 1'b1;
      ROT:     doRot_s  = 1'b1;
      FIN_SUB: doFin_s  = 1'b1;
      default: doLoad_s = 1'b0;
    endcase
    if (tgtA_r) begin
      rotIn_s  = aWork_r;
      rotAmt_s = bWork_r[RTW-1:0];
      subRes_s = aWork_r - iS_sub_i;
    end else begin
      rotIn_s  = bWork_r;
      rotAmt_s = aWork_r[RTW-1:0];
      subRes_s = bWork_r - iS_sub_i;
    end
  end

  rc5_rotr #(
    .W (W)
  ) uRotr (
    .iData (rotIn_s),
    .iRot  (rotAmt_s),
    .oData (rotOut_s)
  );

  // Working registers, key address, round counter and result flag.
  // The final pair of subtracts reuses the target toggle: B at address 1, then A.
  always_ff @(posedge clk) begin
    if (rst || abort_s) begin
      aWork_r <= '0;
      bWork_r <= '0;
      addr_r  <= '0;
      round_r <= '0;
      tgtA_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (doLoad_s) begin
      aWork_r <= iA;
      bWork_r <= iB;
      addr_r  <= AW'(T - 1);
      round_r <= CW'(R);
      tgtA_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (doSub_s || doFin_s) begin
      if (tgtA_r) aWork_r <= subRes_s;
      else        bWork_r <= subRes_s;
      if (doFin_s) begin
        tgtA_r <= ~tgtA_r;
        if (lastAddr_s) done_r <= 1'b1;
        else            addr_r <= addr_r - AW'(1);
      end else begin
        tgtA_r <= tgtA_r;
      end
    end else if (doRot_s) begin
      if (tgtA_r) begin
        aWork_r <= rotOut_s ^ bWork_r;
        round_r <= round_r - CW'(1);
      end else begin
        bWork_r <= rotOut_s ^ aWork_r;
      end
      addr_r <= addr_r - AW'(1);
      tgtA_r <= ~tgtA_r;
    end else begin
      done_r <= done_r;
    end
  end

  assign oA         = aWork_r;
  assign oB         = bWork_r;
  assign oS_address = addr_r;
  assign oDone      = done_r;

endmodule

// File: tb/tb_rc5_decrypt.sv
// Self-checking bench for rc5_decrypt (R=12 and R=1 instances); plaintexts are
// produced by an RC5 encryption/key-expansion reference model. Abort tests
// are compiled when RC5_DEC_ABORT_EN is defined.
module tb_rc5_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        iStart;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [4:0]  sAddr;
  logic [31:0] sData;
  logic [31:0] oA;
  logic [31:0] oB;
  logic        oDone;

  logic        smStart;
  logic [1:0]  smAddr;
  logic [31:0] smData;
  logic [31:0] smOA;
  logic [31:0] smOB;
  logic        smDone;
`ifdef RC5_DEC_ABORT_EN
  logic        iAbort;
  int          doneSeen;
`endif

  logic [31:0] sTab   [26];
  logic [31:0] sTabSm [4];
  logic [4:0]  addrSeq [$];
  logic        doneAfterLoad;
  logic        addrOk;
  logic [63:0] ct;
  logic [31:0] ptA;
  logic [31:0] ptB;
  logic [31:0] holdA;
  int          lat;
  int          nCompared   = 0;
  int          nMismatched = 0;

  always #5 clk = ~clk;

  // Synchronous-read key RAMs
  always @(posedge clk) sData  <= sTab[sAddr];
  always @(posedge clk) smData <= sTabSm[smAddr];

  rc5_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .iStart     (iStart),
    .iA         (iA),
    .iB         (iB),
`ifdef RC5_DEC_ABORT_EN
    .iAbort     (iAbort),
`endif
    .oS_address (sAddr),
    .iS_sub_i   (sData),
    .oA         (oA),
    .oB         (oB),
    .oDone      (oDone)
  );

  rc5_decrypt #(.W(32), .R(1)) dutSmall (
    .clk        (clk),
    .rst        (rst),
    .iStart     (smStart),
    .iA         (32'h0000_0000),
    .iB         (32'h0000_0000),
`ifdef RC5_DEC_ABORT_EN
    .iAbort     (1'b0),
`endif
    .oS_address (smAddr),
    .iS_sub_i   (smData),
    .oA         (smOA),
    .oB         (smOB),
    .oDone      (smDone)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] amt);
    logic [63:0] d;
    d = {x, x} << amt[4:0];
    return d[63:32];
  endfunction

  // Reference RC5-32/12 encryption using the current sTab
  function automatic logic [63:0] encrypt(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a;
    logic [31:0] b;
    a = a0 + sTab[0];
    b = b0 + sTab[1];
    for (int i = 1; i <= 12; i++) begin
      a = rotl32(a ^ b, b) + sTab[2*i];
      b = rotl32(b ^ a, a) + sTab[2*i+1];
    end
    return {a, b};
  endfunction

  task automatic keyExpandZero();
    logic [31:0] l [4];
    logic [31:0] a;
    logic [31:0] b;
    int i;
    int j;
    for (int k = 0; k < 4; k++) l[k] = 32'h0;
    sTab[0] = 32'hB7E1_5163;
    for (int k = 1; k < 26; k++) sTab[k] = sTab[k-1] + 32'h9E37_79B9;
    a = 32'h0; b = 32'h0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      a = rotl32(sTab[i] + a + b, 32'd3);
      sTab[i] = a;
      b = rotl32(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  task automatic randomTable();
    for (int k = 0; k < 26; k++) sTab[k] = $urandom;
  endtask

  // Start one decryption and wait (bounded) for oDone; busy=1 pulses iStart every cycle
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input bit busy, output int latency);
    logic [4:0] lastAddr;
    iA = a; iB = b; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    addrSeq.delete();
    lastAddr = sAddr;
    latency = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (sAddr != lastAddr) begin
        addrSeq.push_back(sAddr);
        lastAddr = sAddr;
      end
      if (cyc == 1) doneAfterLoad = oDone;
      if (oDone) begin
        latency = cyc;
        break;
      end
      iStart = busy;
    end
    iStart = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iStart = 1'b0; smStart = 1'b0; iA = 32'h0; iB = 32'h0;
`ifdef RC5_DEC_ABORT_EN
    iAbort = 1'b0;
`endif
    for (int k = 0; k < 26; k++) sTab[k] = 32'h0;
    for (int k = 0; k < 4; k++) sTabSm[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_oA", 64'(oA), 64'h0);
    check("reset_oB", 64'(oB), 64'h0);
    check("reset_addr", 64'(sAddr), 64'h0);
    check("reset_done", 64'(oDone), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero key table: zero result, 103-cycle latency, addresses 25..0
    runOp(32'h0, 32'h0, 1'b0, lat);
    check("zero_latency", 64'(lat), 64'd103);
    check("zero_result", {oA, oB}, 64'h0);
    addrOk = (addrSeq.size() == 26);
    for (int k = 0; k < addrSeq.size() && k < 26; k++) begin
      if (addrSeq[k] != 5'(25 - k)) addrOk = 1'b0;
    end
    check("addr_sequence", 64'(addrOk), 64'd1);

    // Published known answer with the zero 16-byte key, restarted from DONE
    keyExpandZero();
    runOp(32'hEEDB_A521, 32'h6D8F_4B15, 1'b0, lat);
    check("kat_done_drops", 64'(doneAfterLoad), 64'h0);
    check("kat_latency", 64'(lat), 64'd103);
    check("kat_result", {oA, oB}, 64'h0);

    // Randomized round trips against the encryption model
    for (int n = 0; n < 4; n++) begin
      randomTable();
      ptA = $urandom; ptB = $urandom;
      ct = encrypt(ptA, ptB);
      runOp(ct[63:32], ct[31:0], 1'b0, lat);
      check("rand_result", {oA, oB}, {ptA, ptB});
      check("rand_latency", 64'(lat), 64'd103);
    end
    holdA = ptA;
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", {31'h0, oDone, oA}, {31'h0, 1'b1, holdA});

    // iStart held every busy cycle must be ignored
    randomTable();
    ptA = $urandom; ptB = $urandom;
    ct = encrypt(ptA, ptB);
    runOp(ct[63:32], ct[31:0], 1'b1, lat);
    check("busy_latency", 64'(lat), 64'd103);
    check("busy_result", {oA, oB}, {ptA, ptB});

    // Reset in the middle of an operation
    iA = $urandom; iB = $urandom; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {oA, oB}, 64'h0);
    check("midrst_ctrl", {62'h0, sAddr == 5'd0, oDone}, {62'h0, 1'b1, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    ptA = $urandom; ptB = $urandom;
    ct = encrypt(ptA, ptB);
    runOp(ct[63:32], ct[31:0], 1'b0, lat);
    check("postrst_result", {oA, oB}, {ptA, ptB});
    check("postrst_latency", 64'(lat), 64'd103);

    // R=1 known answer with S={1,2,3,4}
    sTabSm[0] = 32'd1; sTabSm[1] = 32'd2; sTabSm[2] = 32'd3; sTabSm[3] = 32'd4;
    smStart = 1'b1;
    @(posedge clk); #1;
    smStart = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (smDone) begin
        lat = c;
        break;
      end
    end
    check("small_latency", 64'(lat), 64'd15);
    check("small_result", {smOA, smOB}, {32'h0000_0022, 32'hFFFF_FFFA});

`ifdef RC5_DEC_ABORT_EN
    // Abort mid-run: outputs cleared and no result ever appears
    iA = $urandom; iB = $urandom; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    iAbort = 1'b1;
    @(posedge clk); #1;
    iAbort = 1'b0;
    check("abort_outputs", {oA, oB}, 64'h0);
    check("abort_ctrl", {62'h0, sAddr == 5'd0, oDone}, {62'h0, 1'b1, 1'b0});
    doneSeen = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (oDone) doneSeen++;
    end
    check("abort_no_done", 64'(doneSeen), 64'h0);

    // Abort together with reset behaves as reset, then a clean run
    iA = $urandom; iB = $urandom; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    iAbort = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    iAbort = 1'b0; rst = 1'b0;
    check("abortrst_outputs", {oA, oB}, 64'h0);
    check("abortrst_ctrl", {62'h0, sAddr == 5'd0, oDone}, {62'h0, 1'b1, 1'b0});
    ptA = $urandom; ptB = $urandom;
    ct = encrypt(ptA, ptB);
    runOp(ct[63:32], ct[31:0], 1'b0, lat);
    check("abortrst_result", {oA, oB}, {ptA, ptB});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
